// File: rtl/fir_sym_mc_if.sv
// ---------------------------------------------------------------------------
// fir_sym_mc_if
// Purpose : bundles the sample handshake, coefficient write port and result
//           outputs of the symmetric multi-channel FIR (fir_sym_mc).
// Signals :
//   in_valid / in_ready   sample vector handshake
//   in_data               NUM_CH packed samples, channel c at [c*DATA_W +: DATA_W]
//   coef_we/addr/data     coefficient write port
//   out_valid             1-cycle strobe, out_data updated
//   out_data              NUM_CH packed results, channel c at [c*OUT_W +: OUT_W]
//   sample_drop           sticky overrun flag
// Modports: master (sample producer / configuration side), slave (filter).
// ---------------------------------------------------------------------------
interface fir_sym_mc_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 20,
    parameter int ADDR_W = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic                       coef_we;
    logic [ADDR_W-1:0]          coef_addr;
    logic [COEF_W-1:0]          coef_data;
    logic                       out_valid;
    logic [NUM_CH*OUT_W-1:0]    out_data;
    logic                       sample_drop;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, sample_drop
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, sample_drop
    );
endinterface

// File: rtl/fir_sym_mc.sv
// ---------------------------------------------------------------------------
// fir_sym_mc
// Purpose : time-multiplexed symmetric (even-length, linear-phase) FIR low-pass
//           for NUM_CH ADC channels sampled together. One pre-adder and one
//           multiplier are shared by every tap pair and every channel.
// Ports   :
//   CLK_Filter  filter clock
//   rst         asynchronous, active-high reset
//   bus         fir_sym_mc_if.slave: sample handshake, coefficient writes,
//               result strobe/data, sticky sample_drop
// Build option:
//   FIR_ROUND_EN  when defined, add 2^(OUT_SHIFT-1) before the output shift
//                 (round half up); otherwise the shift truncates. Both builds
//                 saturate to 2^OUT_W-1.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready for a sample vector; coefficient writes accepted
// MAC    | one pre-add/multiply/accumulate per cycle, channel-major
// DONE   | publish all channel results, strobe out_valid
// ---------------------------------------------------------------------------
module fir_sym_mc #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int NTAPS     = 22,
    parameter int NUM_CH    = 2,
    parameter int OUT_SHIFT = 0,
    parameter int OUT_W     = 20
) (
    input  logic         CLK_Filter,
    input  logic         rst,
    fir_sym_mc_if.slave  bus
);
    localparam int HALF   = NTAPS / 2;
    localparam int ADDR_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAP_W  = $clog2(NTAPS);
    localparam int ACC_W  = DATA_W + 1 + COEF_W + $clog2(HALF);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;
    localparam int SAT_W  = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;

`ifdef FIR_ROUND_EN
    localparam int             RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic [ACC_W:0] RND     = (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;
`else
    localparam logic [ACC_W:0] RND     = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [ADDR_W-1:0]         k_q, k_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [DATA_W-1:0]         x_q [NUM_CH][NTAPS];
    logic [DATA_W-1:0]         x_d [NUM_CH][NTAPS];
    logic [COEF_W-1:0]         coef_q [HALF];
    logic [COEF_W-1:0]         coef_d [HALF];
    logic [ACC_W-1:0]          hold_q [NUM_CH];
    logic [ACC_W-1:0]          hold_d [NUM_CH];
    logic                      out_valid_q, out_valid_d;
    logic [NUM_CH*OUT_W-1:0]   out_data_q, out_data_d;
    logic                      drop_q, drop_d;

    logic [TAP_W-1:0]          near_idx, far_idx;
    logic [DATA_W-1:0]         x_near, x_far;
    logic [PRE_W-1:0]          pre_sum;
    logic [PROD_W-1:0]         prod;
    logic [ACC_W-1:0]          acc_sum;

    // Bias (rounding build only), shift, then clamp to the output width.
    function automatic logic [OUT_W-1:0] fmt_out(input logic [ACC_W-1:0] a);
        logic [ACC_W:0]   biased;
        logic [SAT_W-1:0] shifted;
        logic [SAT_W-1:0] lim;
        biased  = {1'b0, a} + RND;
        shifted = SAT_W'(biased >> OUT_SHIFT);
        lim     = SAT_W'({OUT_W{1'b1}});
        return (shifted > lim) ? OUT_W'(lim) : OUT_W'(shifted);
    endfunction

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.sample_drop = drop_q;

    // Shared datapath: tap k pairs with its mirror NTAPS-1-k.
    always_comb begin
        near_idx = TAP_W'(k_q);
        far_idx  = TAP_W'(NTAPS - 1) - TAP_W'(k_q);
        x_near   = x_q[ch_q][near_idx];
        x_far    = x_q[ch_q][far_idx];
        pre_sum  = PRE_W'(x_near) + PRE_W'(x_far);
        prod     = PROD_W'(pre_sum) * PROD_W'(coef_q[k_q]);
        acc_sum  = acc_q + ACC_W'(prod);
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        k_d         = k_q;
        acc_d       = acc_q;
        x_d         = x_q;
        coef_d      = coef_q;
        hold_d      = hold_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        drop_d      = drop_q | (bus.in_valid & (state_q != S_IDLE));

        unique case (state_q)
            S_IDLE: begin
                // Written before the sample is taken, so a write in the accepting
                // cycle is already in effect for that sample.
                if (bus.coef_we && ({1'b0, bus.coef_addr} < (ADDR_W + 1)'(HALF))) begin
                    coef_d[bus.coef_addr] = bus.coef_data;
                end
                if (bus.in_valid) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        for (int i = NTAPS - 1; i > 0; i--) begin
                            x_d[c][i] = x_q[c][i-1];
                        end
                        x_d[c][0] = bus.in_data[c*DATA_W +: DATA_W];
                    end
                    acc_d   = '0;
                    ch_d    = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (k_q == ADDR_W'(HALF - 1)) begin
                    hold_d[ch_q] = acc_sum;
                    acc_d        = '0;
                    k_d          = '0;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    acc_d = acc_sum;
                    k_d   = k_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    out_data_d[c*OUT_W +: OUT_W] = fmt_out(hold_q[c]);
                end
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_Filter or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_q      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                hold_q[c] <= '0;
                for (int i = 0; i < NTAPS; i++) begin
                    x_q[c][i] <= '0;
                end
            end
            for (int k = 0; k < HALF; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_q      <= drop_d;
            hold_q      <= hold_d;
            x_q         <= x_d;
            coef_q      <= coef_d;
        end
    end
endmodule

// File: tb/tb_fir_sym_mc.sv
// ---------------------------------------------------------------------------
// tb_fir_sym_mc
// Directed bench for fir_sym_mc. Three instances share one stimulus stream:
//   dut      OUT_SHIFT=0, OUT_W=20 (main instance)
//   dut_sh   OUT_SHIFT=4, OUT_W=20
//   dut_sat  OUT_SHIFT=4, OUT_W=12
// ---------------------------------------------------------------------------
module tb_fir_sym_mc;
`ifdef FIR_ROUND_EN
    localparam int SH_EXP = 8663;
`else
    localparam int SH_EXP = 8662;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_data;

    int total = 0;
    int bad   = 0;
    int cf [11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};

    always #5 clk = ~clk;

    fir_sym_mc_if #(.DATA_W(8), .COEF_W(8), .NUM_CH(2), .OUT_W(20), .ADDR_W(4)) bus0 ();
    fir_sym_mc_if #(.DATA_W(8), .COEF_W(8), .NUM_CH(2), .OUT_W(20), .ADDR_W(4)) bus1 ();
    fir_sym_mc_if #(.DATA_W(8), .COEF_W(8), .NUM_CH(2), .OUT_W(12), .ADDR_W(4)) bus2 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.coef_we   = coef_we;
    assign bus0.coef_addr = coef_addr;
    assign bus0.coef_data = coef_data;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.coef_we   = coef_we;
    assign bus1.coef_addr = coef_addr;
    assign bus1.coef_data = coef_data;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_data   = in_data;
    assign bus2.coef_we   = coef_we;
    assign bus2.coef_addr = coef_addr;
    assign bus2.coef_data = coef_data;

    fir_sym_mc #(.DATA_W(8), .COEF_W(8), .NTAPS(22), .NUM_CH(2), .OUT_SHIFT(0), .OUT_W(20))
        dut (.CLK_Filter(clk), .rst(rst), .bus(bus0));
    fir_sym_mc #(.DATA_W(8), .COEF_W(8), .NTAPS(22), .NUM_CH(2), .OUT_SHIFT(4), .OUT_W(20))
        dut_sh (.CLK_Filter(clk), .rst(rst), .bus(bus1));
    fir_sym_mc #(.DATA_W(8), .COEF_W(8), .NTAPS(22), .NUM_CH(2), .OUT_SHIFT(4), .OUT_W(12))
        dut_sat (.CLK_Filter(clk), .rst(rst), .bus(bus2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_coefs();
        for (int k = 0; k < 11; k++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(k);
            coef_data = 8'(cf[k]);
            tick();
        end
        coef_we = 1'b0;
    endtask

    // Present one vector from IDLE, optionally poke coef[3]=0 during MAC,
    // and return the number of edges from acceptance to out_valid (bounded).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit poke, output int lat);
        in_data  = {b, a};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        if (poke) begin
            coef_we   = 1'b1;
            coef_addr = 4'd3;
            coef_data = 8'd0;
            repeat (3) begin
                tick();
                lat++;
            end
            coef_we = 1'b0;
        end
        while (bus0.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_impulse(input string tag, input bit poke_first);
        int lat;
        int e;
        for (int n = 0; n < 22; n++) begin
            send((n == 0) ? 8'd255 : 8'd0, 8'd0, poke_first && (n == 0), lat);
            e = 255 * cf[(n <= 10) ? n : 21 - n];
            chk($sformatf("%s_lat_n%0d", tag, n), 64'(lat), 64'd23);
            chk($sformatf("%s_ch0_n%0d", tag, n), 64'(bus0.out_data[19:0]), 64'(e));
            chk($sformatf("%s_ch1_n%0d", tag, n), 64'(bus0.out_data[39:20]), 64'd0);
        end
    endtask

    initial begin
        int lat;
        int gap;
        int pulses;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        tick();
        tick();
        chk("rst_in_ready",  64'(bus0.in_ready),    64'd1);
        chk("rst_out_valid", 64'(bus0.out_valid),   64'd0);
        chk("rst_out_data",  64'(bus0.out_data),    64'd0);
        chk("rst_drop",      64'(bus0.sample_drop), 64'd0);
        rst = 1'b0;
        tick();

        // Impulse response
        load_coefs();
        run_impulse("imp", 1'b0);

        // DC: ch0=100, ch1=255; sum(coef)=693
        for (int n = 0; n < 22; n++) begin
            send(8'd100, 8'd255, 1'b0, lat);
            chk($sformatf("dc_lat_n%0d", n), 64'(lat), 64'd23);
        end
        chk("dc_ch0",      64'(bus0.out_data[19:0]),  64'd138600);
        chk("dc_ch1",      64'(bus0.out_data[39:20]), 64'd353430);
        chk("shift4_ch0",  64'(bus1.out_data[19:0]),  64'(SH_EXP));
        chk("shift4_ch1",  64'(bus1.out_data[39:20]), 64'd22089);
        chk("sat12_ch0",   64'(bus2.out_data[11:0]),  64'd4095);
        chk("sat12_ch1",   64'(bus2.out_data[23:12]), 64'd4095);
        tick();
        chk("strobe_one_cycle", 64'(bus0.out_valid),       64'd0);
        chk("out_hold_ch0",     64'(bus0.out_data[19:0]),  64'd138600);

        // Back-pressure: in_valid held high
        in_data  = '0;
        in_valid = 1'b1;
        tick();
        chk("bp_busy_after_accept", 64'(bus0.in_ready),    64'd0);
        chk("bp_drop_before_busy",  64'(bus0.sample_drop), 64'd0);
        tick();
        chk("bp_drop_after_busy",   64'(bus0.sample_drop), 64'd1);
        gap = 1;
        while (bus0.in_ready !== 1'b1 && gap < 40) begin
            tick();
            gap++;
        end
        chk("bp_ready_gap",        64'(gap),            64'd23);
        chk("bp_strobe_at_ready",  64'(bus0.out_valid), 64'd1);
        tick();
        chk("bp_second_accept",    64'(bus0.in_ready),  64'd0);
        in_valid = 1'b0;
        lat = 0;
        while (bus0.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp_second_lat",       64'(lat),            64'd23);

        // Reset 10 cycles into MAC
        in_data  = {8'd200, 8'd200};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready",  64'(bus0.in_ready),    64'd1);
        chk("midrst_out_valid", 64'(bus0.out_valid),   64'd0);
        chk("midrst_out_data",  64'(bus0.out_data),    64'd0);
        chk("midrst_drop",      64'(bus0.sample_drop), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            tick();
            if (bus0.out_valid === 1'b1) pulses++;
        end
        chk("midrst_no_strobe", 64'(pulses), 64'd0);
        send(8'd255, 8'd0, 1'b0, lat);
        chk("midrst_imp_lat", 64'(lat),                   64'd23);
        chk("midrst_imp_ch0", 64'(bus0.out_data[19:0]),   64'd0);

        // Coefficient write during MAC is ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        load_coefs();
        run_impulse("guard", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
